// File: rtl/hs4_sync_sender_pkg.sv
// Shared types for the clocked-to-4-phase sender: FSM state encoding and
// FIFO pointer sizing.
package hs4_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  // Pointer carries one extra wrap bit above the address bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs4_sync_sender_sync_ff.sv
// Plain flop-chain synchronizer for signals arriving from an asynchronous
// domain; all stages clear to 0 on reset.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/hs4_sync_sender.sv
// Bridge from a valid/ready producer into the request side of a 4-phase
// bundled-data pipeline: small FIFO, ack synchronizer and handshake FSM.
module hs4_sync_sender
  import hs4_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             req,
  output logic [WIDTH-1:0] data,
  input  logic             ack,
  output logic             busy,
  output logic             err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             rdy_en;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  logic             ack_s;
  logic             ack_s_p1;
  logic             ack_rise;

  state_t           state;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign in_ready = rdy_en && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign busy     = !empty || (state != IDLE);

  // Holds in_ready low while reset is asserted and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Stage boundary: ack crosses into the clock domain here and nowhere else.
  sync_ff #(
    .WIDTH (1),
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ack),
    .q    (ack_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_s_p1 <= 1'b0;
    else        ack_s_p1 <= ack_s;
  end

  assign ack_rise = ack_s && !ack_s_p1;

  // A word leaves the FIFO only on entry to SETUP.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == IDLE)                 pop = 1'b1;
      if (state == WAIT_REL && !ack_s)   pop = 1'b1;
    end
  end

  // The acknowledge is only honoured on a low-to-high transition seen in
  // WAIT_ACK, so an ack already high from a spurious pulse is not mistaken
  // for the response to this request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req   <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      if (ack_rise && (state == IDLE || state == SETUP)) err <= 1'b1;
      case (state)
        IDLE: begin
          req <= 1'b0;
          if (pop) begin
            data  <= head;
            state <= SETUP;
          end
        end
        SETUP: begin
          req   <= 1'b1;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_rise) begin
            req   <= 1'b0;
            state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          req <= 1'b0;
          if (!ack_s) begin
            if (pop) begin
              data  <= head;
              state <= SETUP;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          req   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs4_sync_sender.sv
// Directed bench for hs4_sync_sender with a timed ack responder and a
// word-order scoreboard checked on every clock.
module tb_hs4_sync_sender;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             req;
  logic [WIDTH-1:0] data;
  logic             ack;
  logic             busy;
  logic             err;

  logic ack_model = 1'b0;
  logic ack_force = 1'b0;
  logic ack_en    = 1'b1;
  assign ack = ack_model | ack_force;

  int npass  = 0;
  int ntotal = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       exp_err     = 1'b0;
  logic       err_dc      = 1'b0;
  logic       req_low_chk = 1'b0;

  always #5 clk = ~clk;

  hs4_sync_sender #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .req     (req),
    .data    (data),
    .ack     (ack),
    .busy    (busy),
    .err     (err)
  );

  // Pipeline side: ack follows req 10 ns later in both directions.
  always begin
    wait (ack_en && (req !== ack_model));
    #10;
    if (ack_en) ack_model = req;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    ntotal++;
    if (act === expv) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // Every clock: a word is taken on each req rise and must be the next
  // accepted word; data must not move while req is high.
  logic       prev_req  = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req  = 1'b0;
      prev_data = '0;
    end else begin
      if (req && !prev_req) begin
        chk("setup_before_req", 32'(data), 32'(prev_data));
        if (exp_q.size() == 0) chk("unexpected_word", 32'(data), 32'hFFFF_FFFF);
        else                   chk("word_order", 32'(data), 32'(exp_q.pop_front()));
        rx_q.push_back(data);
      end else if (req && prev_req) begin
        chk("data_stable", 32'(data), 32'(prev_data));
      end
      if (!err_dc)     chk("err_flag", 32'(err), 32'(exp_err));
      if (req_low_chk) chk("req_quiet", 32'(req), 32'd0);
      prev_req  = req;
      prev_data = data;
    end
  end

  task automatic push(input logic [7:0] w, output logic acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    acc      = in_ready;
    @(posedge clk);
    if (acc) exp_q.push_back(w);
    #1 in_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [7:0] w);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      push(w, acc);
      n++;
    end
    chk("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(req), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic       acc;
    logic [7:0] burst [4];
    int         n;
    burst = '{8'hAA, 8'h55, 8'h0F, 8'hF0};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req",      32'(req),      32'd0);
    chk("rst_data",     32'(data),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 chk("rel_ready_after_edge", 32'(in_ready), 32'd1);

    // Single word: data at E1, req at E2.
    rx_q.delete();
    push(8'hAA, acc);
    chk("single_acc", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    chk("single_data_e1", 32'(data), 32'hAA);
    chk("single_req_e1",  32'(req),  32'd0);
    @(posedge clk);
    #1 chk("single_req_e2", 32'(req), 32'd1);
    wait_idle("single_idle");
    chk("single_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("single_word", 32'(rx_q[0]), 32'hAA);

    // Back-to-back burst.
    rx_q.delete();
    for (int i = 0; i < 4; i++) begin
      push(burst[i], acc);
      chk("burst_ready", 32'(acc), 32'd1);
    end
    wait_idle("burst_idle");
    chk("burst_count", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("burst_word", 32'(rx_q[i]), 32'(burst[i]));

    // Full FIFO with ack withheld.
    ack_en = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      push(8'h10 + 8'(i), acc);
      chk("full_acc", 32'(acc), (i < 5) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("full_req",      32'(req),      32'd1);
    chk("full_data",     32'(data),     32'h10);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_busy",     32'(busy),     32'd1);
    ack_en = 1'b1;
    n = 0;
    while (data !== 8'h11 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("full_next_word", 32'(data),     32'h11);
    chk("full_ready_pop", 32'(in_ready), 32'd1);
    wait_idle("full_idle");
    chk("full_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("full_word", 32'(rx_q[i]), 32'h10 + 32'(i));

    // Pointer wrap-around: 3*DEPTH+1 words.
    rx_q.delete();
    for (int i = 0; i < 3 * DEPTH + 1; i++) push_wait(8'(i));
    wait_idle("wrap_idle");
    chk("wrap_count", 32'(rx_q.size()), 32'(3 * DEPTH + 1));
    for (int i = 0; i < rx_q.size(); i++) chk("wrap_word", 32'(rx_q[i]), 32'(i));

    // Spurious ack while idle.
    err_dc      = 1'b1;
    req_low_chk = 1'b1;
    @(negedge clk);
    #2 ack_force = 1'b1;
    #20 ack_force = 1'b0;
    repeat (6) @(negedge clk);
    chk("spur_err", 32'(err), 32'd1);
    exp_err     = 1'b1;
    err_dc      = 1'b0;
    req_low_chk = 1'b0;
    rx_q.delete();
    push_wait(8'h3C);
    wait_idle("spur_idle");
    chk("spur_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("spur_word", 32'(rx_q[0]), 32'h3C);
    chk("spur_err_sticky", 32'(err), 32'd1);

    // Reset in the middle of a handshake.
    ack_en = 1'b0;
    push_wait(8'h99);
    wait_req("mid_req_up");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_req",      32'(req),      32'd0);
    chk("mid_rst_data",     32'(data),     32'd0);
    chk("mid_rst_busy",     32'(busy),     32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_err",      32'(err),      32'd0);
    exp_q.delete();
    exp_err   = 1'b0;
    ack_model = 1'b0;
    repeat (2) @(negedge clk);
    ack_en = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready0", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 chk("mid_rel_ready1", 32'(in_ready), 32'd1);
    rx_q.delete();
    push_wait(8'h55);
    wait_idle("mid_idle");
    chk("mid_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("mid_word", 32'(rx_q[0]), 32'h55);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
